// File: rtl/spike_rate_encoder.sv
// Rate-codes a pixel intensity into a spike train over a programmable window.
// A spike fires when the low LFSR bits fall below the pixel value; a full-scale pixel always fires.
module spike_rate_encoder #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          WINDOW_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic                    spike_out,
    output logic                    busy,
    output logic                    done,
    output logic [WINDOW_WIDTH-1:0] spike_count
);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [15:0]             SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0]             TAPS     = 16'hB400;
    localparam logic [DATA_WIDTH-1:0]   PIX_MAX  = '1;
    localparam logic [WINDOW_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WINDOW_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WINDOW_WIDTH-1:0] CNT_ONE  = WINDOW_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]   pixel_q, pixel_d;
    logic [WINDOW_WIDTH-1:0] len_q, len_d;
    logic [WINDOW_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [WINDOW_WIDTH-1:0] spike_count_q, spike_count_d;
    logic                    spike_out_q, spike_out_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    pixel_ready_q, pixel_ready_d;
    logic                    spike_bit;

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        pixel_d       = pixel_q;
        len_d         = len_q;
        ts_cnt_d      = ts_cnt_q;
        spike_count_d = spike_count_q;
        spike_out_d   = spike_out_q;
        done_d        = 1'b0;
        spike_bit     = (pixel_q == PIX_MAX) || (lfsr_q[DATA_WIDTH-1:0] < pixel_q);

        case (state_q)
            IDLE: begin
                if (pixel_valid) begin
                    pixel_d       = pixel_in;
                    len_d         = window_len;
                    ts_cnt_d      = CNT_ZERO;
                    spike_count_d = CNT_ZERO;
                    state_d       = (window_len == CNT_ZERO) ? DONE_ST : RUN;
                end
            end
            RUN: begin
                spike_out_d = spike_bit;
                if (spike_bit && (spike_count_q != CNT_MAX)) begin
                    spike_count_d = spike_count_q + CNT_ONE;
                end
                lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
                ts_cnt_d = ts_cnt_q + CNT_ONE;
                if (ts_cnt_q == (len_q - CNT_ONE)) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                spike_out_d = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d        = (state_d != IDLE);
        pixel_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            pixel_q       <= '0;
            len_q         <= '0;
            ts_cnt_q      <= '0;
            spike_count_q <= '0;
            spike_out_q   <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            pixel_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            pixel_q       <= pixel_d;
            len_q         <= len_d;
            ts_cnt_q      <= ts_cnt_d;
            spike_count_q <= spike_count_d;
            spike_out_q   <= spike_out_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            pixel_ready_q <= pixel_ready_d;
        end
    end

    assign pixel_ready = pixel_ready_q;
    assign spike_out   = spike_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_count = spike_count_q;

endmodule
